// File: rtl/spi_responder_pkg.sv
// Shared types and constants for the SPI responder.
package spi_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  localparam int RX_FIFO_DEPTH = 4;

  // bit_cnt only needs to reach DATA_W-1 before wrapping on word completion.
  function automatic int bit_cnt_width(input int data_w);
    return (data_w > 1) ? $clog2(data_w) : 1;
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer with a history flop and registered rise/fall pulses.
module spi_sync_edge #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], din};
      hist_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~hist_q;
      fall   <= ~sync_q[STAGES-1] & hist_q;
    end
  end

  // Level is aligned with the edge pulses, so data sampled on a rise pulse is the value seen at that edge.
  assign level = hist_q;

endmodule

// File: rtl/spi_responder.sv
// SPI mode-0 responder with valid/ready RX/TX streams.
// Optional SPI_RESPONDER_RX_FIFO_EN: 4-entry RX FIFO instead of a single RX register.
//
// state    | meaning
// ST_IDLE  | not selected, MISO tri-stated
// ST_LOAD  | first TX word sits in shift_tx, MISO driven, waiting one cycle
// ST_SHIFT | clocking bits in on SCLK rise and out on SCLK fall
module spi_responder
  import spi_responder_pkg::*;
#(
  parameter int                DATA_W      = 8,
  parameter logic [DATA_W-1:0] IDLE_WORD   = '1,
  parameter int                SYNC_STAGES = 2
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              spi_SCLK,
  input  logic              spi_MOSI,
  input  logic              spi_SS_n,
  output logic              spi_MISO,
  output logic              spi_MISO_oe,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  input  logic              rx_ready,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic              status_clear,
  output logic              rx_overflow,
  output logic              tx_underrun
);

  localparam int CNT_W = bit_cnt_width(DATA_W);

  logic sclk_rise, sclk_fall, sclk_level;
  logic mosi_bit, mosi_rise, mosi_fall;
  logic sel_start, sel_end, ss_level;
  logic unused_sync;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .din(spi_SCLK),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .din(spi_MOSI),
    .level(mosi_bit), .rise(mosi_rise), .fall(mosi_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_ss (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n), .din(spi_SS_n),
    .level(ss_level), .rise(sel_end), .fall(sel_start)
  );

  assign unused_sync = sclk_level ^ mosi_rise ^ mosi_fall ^ ss_level;

  state_t state_q, state_d;
  logic   miso_oe;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) state_q <= ST_IDLE;
    else                state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    miso_oe = 1'b0;
    case (state_q)
      ST_IDLE:  if (sel_start) state_d = ST_LOAD;
      ST_LOAD:  begin
        miso_oe = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: miso_oe = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
    if (sel_end) state_d = ST_IDLE;
  end

  logic [DATA_W-1:0] shift_tx_q, shift_rx_q, hold_q, tx_word, rx_word;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              load_pend_q, hold_full_q, underrun_q, overflow_q;
  logic              in_shift, rx_shift, word_done, load_first, load_next;
  logic              tx_load, tx_shift, rx_push, rx_pop, ovf_set;

  // The first word is loaded on the cycle sel_start is seen so MISO is valid as LOAD begins.
  assign load_first = (state_q == ST_IDLE) && sel_start;
  assign in_shift   = (state_q == ST_SHIFT) && !sel_end;
  assign rx_shift   = in_shift && sclk_rise;
  assign word_done  = rx_shift && (bit_cnt_q == CNT_W'(DATA_W - 1));
  assign load_next  = in_shift && sclk_fall && load_pend_q;
  assign tx_load    = load_first || load_next;
  assign tx_shift   = in_shift && sclk_fall && (bit_cnt_q != '0);
  assign tx_word    = hold_full_q ? hold_q : IDLE_WORD;
  assign rx_word    = {shift_rx_q[DATA_W-2:0], mosi_bit};
  assign ovf_set    = word_done && !rx_push;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      shift_tx_q  <= IDLE_WORD;
      shift_rx_q  <= '0;
      bit_cnt_q   <= '0;
      load_pend_q <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      if (tx_load)       shift_tx_q <= tx_word;
      else if (tx_shift) shift_tx_q <= {shift_tx_q[DATA_W-2:0], 1'b0};

      if (load_first)    bit_cnt_q <= '0;
      else if (rx_shift) bit_cnt_q <= word_done ? '0 : bit_cnt_q + CNT_W'(1);

      if (rx_shift) shift_rx_q <= rx_word;

      if (word_done) load_pend_q <= 1'b1;
      else if (tx_load || !in_shift) load_pend_q <= 1'b0;

      // A handshake only happens while empty, so a same-cycle load drains nothing the new word needs.
      if (tx_valid && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end else if (tx_load) begin
        hold_full_q <= 1'b0;
      end

      if (tx_load && !hold_full_q) underrun_q <= 1'b1;
      else if (status_clear)       underrun_q <= 1'b0;

      if (ovf_set)           overflow_q <= 1'b1;
      else if (status_clear) overflow_q <= 1'b0;
    end
  end

`ifdef SPI_RESPONDER_RX_FIFO_EN
  localparam int PTR_W  = $clog2(RX_FIFO_DEPTH);
  localparam int FCNT_W = PTR_W + 1;

  logic [DATA_W-1:0] fifo_mem [RX_FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [FCNT_W-1:0] fifo_cnt_q;

  assign rx_pop  = (fifo_cnt_q != '0) && rx_ready;
  assign rx_push = word_done && ((fifo_cnt_q != FCNT_W'(RX_FIFO_DEPTH)) || rx_pop);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < RX_FIFO_DEPTH; i++) fifo_mem[i] <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      if (rx_push) begin
        fifo_mem[wr_ptr_q] <= rx_word;
        wr_ptr_q           <= wr_ptr_q + PTR_W'(1);
      end
      if (rx_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({rx_push, rx_pop})
        2'b10:   fifo_cnt_q <= fifo_cnt_q + FCNT_W'(1);
        2'b01:   fifo_cnt_q <= fifo_cnt_q - FCNT_W'(1);
        default: fifo_cnt_q <= fifo_cnt_q;
      endcase
    end
  end

  assign rx_valid = (fifo_cnt_q != '0);
  assign rx_data  = fifo_mem[rd_ptr_q];
`else
  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;

  assign rx_pop  = rx_valid_q && rx_ready;
  assign rx_push = word_done && (!rx_valid_q || rx_ready);

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else if (rx_push) begin
      rx_data_q  <= rx_word;
      rx_valid_q <= 1'b1;
    end else if (rx_pop) begin
      rx_valid_q <= 1'b0;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
`endif

  assign spi_MISO    = shift_tx_q[DATA_W-1];
  assign spi_MISO_oe = miso_oe;
  assign tx_ready    = !hold_full_q;
  assign rx_overflow = overflow_q;
  assign tx_underrun = underrun_q;

endmodule

// File: tb/tb_spi_responder.sv
// Self-checking bench for spi_responder: directed scenarios plus randomized frames
// checked against a queue-based model of words, flags and MISO data.
module tb_spi_responder;

  localparam int         DW   = 8;
  localparam int         SYNC = 2;
  localparam int         HALF = 4;
  localparam logic [7:0] IDLE = 8'hFF;
`ifdef SPI_RESPONDER_RX_FIFO_EN
  localparam int RX_CAP = 4;
`else
  localparam int RX_CAP = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0, spi_mosi = 1'b0, ss_n = 1'b1;
  logic       spi_MISO, spi_MISO_oe;
  logic [7:0] rx_data, tx_data = '0;
  logic       rx_valid, rx_ready = 1'b1, tx_valid = 1'b0, tx_ready;
  logic       status_clear = 1'b0, rx_overflow, tx_underrun;

  spi_responder #(.DATA_W(DW), .IDLE_WORD(IDLE), .SYNC_STAGES(SYNC)) dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .spi_SCLK(sclk), .spi_MOSI(spi_mosi), .spi_SS_n(ss_n),
    .spi_MISO(spi_MISO), .spi_MISO_oe(spi_MISO_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .status_clear(status_clear), .rx_overflow(rx_overflow), .tx_underrun(tx_underrun)
  );

  always #5 clk = ~clk;

  int         n_checks = 0, n_pass = 0, n_extra = 0;
  logic [7:0] feed_q[$], exp_tx_q[$], exp_rx_q[$], mosi_words[$];
  logic       exp_under = 1'b0, exp_ovf = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: each word slot the responder starts consumes the oldest pending TX word, or IDLE.
  function automatic logic [7:0] model_load();
    if (exp_tx_q.size() > 0) return exp_tx_q.pop_front();
    exp_under = 1'b1;
    return IDLE;
  endfunction

  function automatic void model_rx(input logic [7:0] w);
    if (exp_rx_q.size() < RX_CAP) exp_rx_q.push_back(w);
    else exp_ovf = 1'b1;
  endfunction

  task automatic give_tx(input logic [7:0] w);
    feed_q.push_back(w);
    exp_tx_q.push_back(w);
  endtask

  task automatic check_flags(input string pfx);
    check_val({pfx, "_underrun"}, tx_underrun, exp_under);
    check_val({pfx, "_overflow"}, rx_overflow, exp_ovf);
  endtask

  task automatic clear_flags();
    status_clear = 1'b1;
    tick(1);
    status_clear = 1'b0;
    exp_under = 1'b0;
    exp_ovf   = 1'b0;
  endtask

  task automatic check_reset(input string pfx);
    check_val({pfx, "_miso"},     spi_MISO, 1'b1);
    check_val({pfx, "_miso_oe"},  spi_MISO_oe, 1'b0);
    check_val({pfx, "_rx_valid"}, rx_valid, 1'b0);
    check_val({pfx, "_rx_data"},  rx_data, 8'h00);
    check_val({pfx, "_tx_ready"}, tx_ready, 1'b1);
    check_val({pfx, "_overflow"}, rx_overflow, 1'b0);
    check_val({pfx, "_underrun"}, tx_underrun, 1'b0);
  endtask

  // Mode-0 master: n_words full words from mosi_words, then an optional partial word.
  // The final SCLK fall and SS_n rise are driven together.
  task automatic spi_frame(input int n_words, input int partial, input bit chk_lat);
    logic [7:0] word, exp_miso, got;
    int nbits, lat, n_slots;
    n_slots = n_words + ((partial > 0) ? 1 : 0);
    ss_n = 1'b0;
    for (int w = 0; w < n_slots; w++) begin
      nbits = (w < n_words) ? DW : partial;
      if (w < n_words) word = mosi_words.pop_front();
      else             word = 8'($urandom);
      exp_miso = model_load();
      got = '0;
      for (int b = 0; b < nbits; b++) begin
        spi_mosi = word[DW-1-b];
        tick(HALF);
        if (b == 0) check_val("miso_oe", spi_MISO_oe, 1'b1);
        got  = {got[6:0], spi_MISO};
        sclk = 1'b1;
        if (b == nbits - 1 && w < n_words) begin
          model_rx(word);
          lat = 0;
          for (int k = 1; k <= HALF; k++) begin
            tick(1);
            if (lat == 0 && rx_valid) lat = k;
          end
          if (chk_lat) check_val("rx_latency", lat, SYNC + 2);
        end else begin
          tick(HALF);
        end
        sclk = 1'b0;
        if (b == nbits - 1 && w == n_slots - 1) ss_n = 1'b1;
      end
      if (w < n_words) check_val("miso_word", got, exp_miso);
    end
    tick(2 * HALF);
    check_val("miso_oe_idle", spi_MISO_oe, 1'b0);
  endtask

  initial begin : feeder
    forever begin
      @(posedge clk);
      if (tx_valid && tx_ready) void'(feed_q.pop_front());
      #1;
      tx_valid = (feed_q.size() > 0);
      tx_data  = (feed_q.size() > 0) ? feed_q[0] : 8'h00;
    end
  end

  always @(negedge clk) begin : rx_monitor
    logic [7:0] e;
    if (rst_n && rx_valid && rx_ready) begin
      if (exp_rx_q.size() == 0) begin
        n_extra++;
      end else begin
        e = exp_rx_q.pop_front();
        check_val("rx_data", rx_data, e);
      end
    end
  end

  initial begin : stim
    logic [7:0] first;
    int nw, np, ntx;

    tick(3);
    check_reset("rst");
    rst_n = 1'b1;
    tick(3);
    check_reset("post_rst");

    give_tx(8'hA5);
    tick(4);
    mosi_words.push_back(8'h3C);
    spi_frame(1, 0, 1'b1);
    check_flags("single");

    mosi_words.push_back(8'h81);
    spi_frame(1, 0, 1'b1);
    check_flags("no_tx");
    clear_flags();
    check_flags("no_tx_clr");

    give_tx(8'h01); give_tx(8'h02); give_tx(8'h03);
    tick(4);
    mosi_words.push_back(8'h10); mosi_words.push_back(8'h20); mosi_words.push_back(8'h30);
    spi_frame(3, 0, 1'b1);
    check_flags("burst");

    spi_frame(0, 5, 1'b0);
    mosi_words.push_back(8'h55);
    spi_frame(1, 0, 1'b1);
    check_flags("abort");
    clear_flags();

    rx_ready = 1'b0;
    first = 8'hC3;
    mosi_words.push_back(first);
    for (int i = 1; i <= RX_CAP; i++) mosi_words.push_back(8'(8'h40 + i));
    spi_frame(RX_CAP + 1, 0, 1'b0);
    check_flags("ovf");
    check_val("ovf_rx_valid", rx_valid, 1'b1);
    check_val("ovf_hold", rx_data, first);
    rx_ready = 1'b1;
    tick(2 * RX_CAP + 4);
    check_val("ovf_drained", exp_rx_q.size(), 0);
    clear_flags();
    check_flags("ovf_clr");

    ss_n = 1'b0;
    void'(model_load());
    for (int b = 0; b < 3; b++) begin
      spi_mosi = 1'($urandom);
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(1);
    rst_n = 1'b0;
    ss_n  = 1'b1;
    tick(1);
    check_reset("mid_rst");
    exp_under = 1'b0;
    exp_ovf   = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(4);
    mosi_words.push_back(8'h5A);
    spi_frame(1, 0, 1'b1);
    check_flags("after_rst");

    for (int it = 0; it < 24; it++) begin
      nw  = $urandom_range(1, 3);
      np  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1) : 0;
      ntx = $urandom_range(0, nw + 1);
      for (int i = 0; i < ntx; i++) give_tx(8'($urandom));
      for (int i = 0; i < nw; i++) mosi_words.push_back(8'($urandom));
      tick(4);
      spi_frame(nw, np, 1'b1);
      check_flags("rand");
      if ($urandom_range(0, 1) == 1) begin
        clear_flags();
        check_flags("rand_clr");
      end
    end

    tick(10);
    check_val("rx_missing", exp_rx_q.size(), 0);
    check_val("rx_extra", n_extra, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
